// File: rtl/cb_seg_engine.sv
// cb_seg_engine: splits one TB into C code blocks (fillers, data, CRC24B tail) on a serial valid/ready stream.
// Define CB_SEG_SIZE_CHECK_EN to reject B==0 or oversize B with a one-cycle err pulse.
module cb_seg_engine #(
  parameter int SIZE_W = 16,
  parameter int C_W = 4,
  parameter int Z = 6144,
  parameter int L = 24,
  parameter int KGRAN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SIZE_W-1:0] tb_size,
  input  logic              size_vld,
  output logic              size_rdy,
  input  logic              tb_in,
  input  logic              tb_vld,
  output logic              tb_rdy,
  output logic              cb_data,
  output logic              cb_vld,
  input  logic              cb_rdy,
  output logic              start,
  output logic              stop,
  output logic              filling,
  output logic              crc,
  output logic [SIZE_W-1:0] cb_size,
  output logic [C_W-1:0]    cb_idx,
  output logic [C_W-1:0]    cb_num,
  output logic              busy
`ifdef CB_SEG_SIZE_CHECK_EN
  ,output logic             err
`endif
);
  localparam int W = SIZE_W + 2;
  localparam logic [W-1:0] ZL = W'(Z - L);
  localparam logic [W-1:0] ZW = W'(Z);
  localparam logic [W-1:0] LW = W'(L);
  localparam logic [W-1:0] KW = W'(KGRAN);
  localparam logic [SIZE_W-1:0] LS = SIZE_W'(L);
  localparam logic [SIZE_W-1:0] KS = SIZE_W'(KGRAN);
  localparam logic [23:0] POLY = 24'h800063;
  typedef enum logic [2:0] {IDLE, CALC_C, CALC_K, FILL, DATA, CRC} state_t;
  state_t state, state_n;
  logic [W-1:0] rem, bp, ck, prod;
  logic [SIZE_W-1:0] k, f, cnt, fn, fsel, d0;
  logic [C_W-1:0] c, idx;
  logic [23:0] crc_r, crc_nxt;
  logic first, big, accept, bad, xfer, last, c_one, last_blk, c_done;
  assign accept = size_vld & (state == IDLE);
`ifdef CB_SEG_SIZE_CHECK_EN
  localparam logic [31:0] MAX_B = 32'(((2 ** C_W) - 1) * (Z - L));
  assign bad = (tb_size == '0) || (32'(tb_size) > MAX_B);
`else
  assign bad = 1'b0;
`endif
  assign size_rdy = state == IDLE;
  assign busy = !size_rdy;
  assign cb_size = k;
  assign cb_idx = idx;
  assign cb_num = c;
  assign c_one = c == C_W'(1);
  assign last = cnt == SIZE_W'(1);
  assign last_blk = idx == c - 1'b1;
  assign c_done = !big || rem <= ZL;
  assign fn = SIZE_W'(prod - bp);
  assign fsel = (state == CALC_K) ? fn : f;
  // data beats of block 0; zero only for an empty TB (fillers only)
  assign d0 = k - fsel - (c_one ? '0 : LS);
  assign crc_nxt = {crc_r[22:0], 1'b0} ^ ((((state == DATA) & tb_in) ^ crc_r[23]) ? POLY : 24'd0);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cb_vld = 1'b0;
    cb_data = 1'b0;
    tb_rdy = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    filling = 1'b0;
    crc = 1'b0;
    xfer = 1'b0;
    case (state)
      IDLE: state_n = (accept && !bad) ? CALC_C : IDLE;
      CALC_C: state_n = c_done ? CALC_K : CALC_C;
      CALC_K: state_n = (prod >= bp) ? ((fn != '0) ? FILL : DATA) : CALC_K;
      FILL: begin
        cb_vld = 1'b1;
        filling = 1'b1;
        start = first;
        stop = last && d0 == '0;
        xfer = cb_rdy;
        if (xfer && last) state_n = (d0 == '0) ? IDLE : DATA;
      end
      DATA: begin
        cb_data = tb_in;
        cb_vld = tb_vld;
        tb_rdy = cb_rdy;
        start = first;
        stop = last && c_one;
        xfer = tb_vld & cb_rdy;
        if (xfer && last) state_n = c_one ? IDLE : CRC;
      end
      CRC: begin
        cb_vld = 1'b1;
        crc = 1'b1;
        cb_data = crc_r[23];
        stop = last;
        xfer = cb_rdy;
        if (xfer && last) state_n = last_blk ? IDLE : DATA;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      bp <= '0;
      ck <= '0;
      prod <= '0;
      k <= '0;
      f <= '0;
      cnt <= '0;
      c <= '0;
      idx <= '0;
      crc_r <= '0;
      first <= 1'b0;
      big <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept && !bad) begin
          rem <= W'(tb_size);
          bp <= W'(tb_size);
          big <= W'(tb_size) > ZW;
          c <= '0;
          ck <= '0;
          idx <= '0;
          crc_r <= '0;
          first <= 1'b1;
        end
        CALC_C: begin
          c <= c + 1'b1;
          ck <= ck + KW;
          bp <= bp + (big ? LW : '0);
          rem <= rem - ZL;
          k <= KS;
          prod <= ck + KW;
        end
        CALC_K: if (prod >= bp) begin
          f <= fn;
          cnt <= (fn != '0) ? fn : d0;
        end else begin
          k <= k + KS;
          prod <= prod + ck;
        end
        FILL: if (xfer) begin
          crc_r <= crc_nxt;
          cnt <= last ? d0 : cnt - 1'b1;
          first <= 1'b0;
        end
        DATA: if (xfer) begin
          crc_r <= crc_nxt;
          cnt <= last ? LS : cnt - 1'b1;
          first <= 1'b0;
        end
        CRC: if (xfer) begin
          crc_r <= last ? 24'd0 : {crc_r[22:0], 1'b0};
          cnt <= last ? k - LS : cnt - 1'b1;
          first <= last && !last_blk;
          idx <= (last && !last_blk) ? idx + 1'b1 : idx;
        end
        default: ;
      endcase
    end
`ifdef CB_SEG_SIZE_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err <= 1'b0;
    else err <= accept && bad;
`endif
endmodule

// File: tb/tb_cb_seg_engine.sv
// tb_cb_seg_engine: random-stimulus bench for cb_seg_engine against a segmentation/CRC reference model.
module tb_cb_seg_engine;
  localparam int Z = 6144, L = 24, KGRAN = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] tb_size = '0, cb_size;
  logic size_vld = 1'b0, tb_in = 1'b0, tb_vld = 1'b0, cb_rdy = 1'b0;
  logic size_rdy, tb_rdy, cb_data, cb_vld, start, stop, filling, crc, busy;
  logic [3:0] cb_idx, cb_num;
`ifdef CB_SEG_SIZE_CHECK_EN
  logic err;
`endif
  int checks = 0, failures = 0;
  bit tb_bits[$];
  logic [28:0] exp_q[$], log_q[$], ref_log[$];
  int n_fill, n_crc;
  logic [15:0] k_obs;

  cb_seg_engine dut (
    .clk(clk), .reset(reset), .tb_size(tb_size), .size_vld(size_vld), .size_rdy(size_rdy),
    .tb_in(tb_in), .tb_vld(tb_vld), .tb_rdy(tb_rdy), .cb_data(cb_data), .cb_vld(cb_vld),
    .cb_rdy(cb_rdy), .start(start), .stop(stop), .filling(filling), .crc(crc),
    .cb_size(cb_size), .cb_idx(cb_idx), .cb_num(cb_num), .busy(busy)
`ifdef CB_SEG_SIZE_CHECK_EN
    ,.err(err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // remainder of M(x)*x^24 divided by the CRC24B generator
  function automatic logic [23:0] crc24(input bit m[$]);
    logic [24:0] r = '0;
    foreach (m[i]) begin
      r = {r[23:0], m[i]};
      if (r[24]) r ^= 25'h1800063;
    end
    repeat (24) begin
      r = {r[23:0], 1'b0};
      if (r[24]) r ^= 25'h1800063;
    end
    return r[23:0];
  endfunction

  task automatic gen_bits(input int n);
    tb_bits.delete();
    repeat (n) tb_bits.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic build_model(input int b_sz);
    int nc, bp, k, f, p, n;
    bit blk[$];
    int kind[$];
    logic [23:0] cr;
    nc = (b_sz <= Z) ? 1 : (b_sz + (Z - L) - 1) / (Z - L);
    bp = b_sz + ((nc > 1) ? nc * L : 0);
    k = ((bp + nc * KGRAN - 1) / (nc * KGRAN)) * KGRAN;
    if (k < KGRAN) k = KGRAN;
    f = nc * k - bp;
    p = 0;
    exp_q.delete();
    for (int b = 0; b < nc; b++) begin
      blk.delete();
      kind.delete();
      if (b == 0) repeat (f) begin blk.push_back(1'b0); kind.push_back(1); end
      n = (nc == 1) ? k - f : (b == 0) ? k - f - L : k - L;
      repeat (n) begin blk.push_back(tb_bits[p]); kind.push_back(0); p++; end
      if (nc > 1) begin
        cr = crc24(blk);
        for (int i = 23; i >= 0; i--) begin blk.push_back(cr[i]); kind.push_back(2); end
      end
      foreach (blk[i])
        exp_q.push_back({4'(b), 4'(nc), 16'(k), blk[i], i == 0, i == blk.size() - 1,
                         kind[i] == 1, kind[i] == 2});
    end
  endtask

  // mode 0: always ready; mode 1: cb_rdy 1-of-3 with tb_vld held; mode 2: random both sides
  task automatic run(input int b_sz, input int mode, input int abort_at);
    int bi, ptr, cyc, budget;
    bit pend, held_v;
    logic [28:0] vec, held;
    build_model(b_sz);
    log_q.delete();
    n_fill = 0;
    n_crc = 0;
    k_obs = '0;
    tb_size = 16'(b_sz);
    size_vld = 1'b1;
    @(posedge clk); #1;
    size_vld = 1'b0;
    check("accept", {busy, size_rdy}, 2'b10);
    bi = 0; ptr = 0; cyc = 0; pend = 0; held_v = 0; held = '0;
    budget = 40 * exp_q.size() + 2000;
    while (bi < exp_q.size() && cyc < budget) begin
      cb_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
      if (!pend) tb_vld = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tb_in = (ptr < b_sz) ? tb_bits[ptr] : 1'b0;
      if (mode == 2) begin
        size_vld = $urandom_range(0, 7) == 0;
        tb_size = 16'($urandom);
      end
      @(negedge clk);
      vec = {cb_idx, cb_num, cb_size, cb_data, start, stop, filling, crc};
      if (held_v) check("hold", {cb_vld, vec}, {1'b1, held});
      held_v = cb_vld && !cb_rdy;
      held = vec;
      if (cb_vld && cb_rdy) begin
        check("beat", vec, exp_q[bi]);
        log_q.push_back(vec);
        if (bi == 0) k_obs = cb_size;
        n_fill += int'(filling);
        n_crc += int'(crc);
        bi++;
      end
      if (tb_vld && tb_rdy) ptr++;
      pend = tb_vld && !tb_rdy;
      if (abort_at > 0 && bi == abort_at) begin
        size_vld = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_out", {cb_vld, cb_data, tb_rdy, start, stop, filling, crc, busy,
                          cb_size, cb_idx, cb_num, size_rdy}, 64'd1);
        tb_vld = 1'b0;
        cb_rdy = 1'b0;
        @(posedge clk); #1;
        check("rst_hold", {busy, size_rdy, tb_rdy}, 3'b010);
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    size_vld = 1'b0;
    tb_vld = 1'b0;
    check("beats", bi, exp_q.size());
    check("consumed", ptr, b_sz);
    @(posedge clk); #1;
    check("idle", {size_rdy, busy, tb_rdy, cb_vld}, 4'b1000);
  endtask

  initial begin
    int d, b;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {cb_vld, cb_data, tb_rdy, start, stop, filling, crc, busy,
                          cb_size, cb_idx, cb_num, size_rdy}, 64'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    gen_bits(40);
    run(40, 0, 0);
    check("k_40", k_obs, 40);
    check("fill_40", n_fill, 0);
    check("crc_40", n_crc, 0);

    gen_bits(100);
    run(100, 2, 0);
    check("k_100", k_obs, 104);
    check("fill_100", n_fill, 4);

    gen_bits(6145);
    run(6145, 0, 0);
    check("k_6145", k_obs, 3104);
    check("fill_6145", n_fill, 15);
    check("crc_6145", n_crc, 48);
    ref_log = log_q;
    run(6145, 1, 0);
    d = (log_q.size() != ref_log.size()) ? 1 : 0;
    for (int i = 0; i < log_q.size() && i < ref_log.size(); i++) d += (log_q[i] !== ref_log[i]) ? 1 : 0;
    check("stall_seq", d, 0);

    run(6145, 2, 3104 + 500);
    gen_bits(40);
    run(40, 0, 0);
    check("k_40_after_rst", k_obs, 40);

    gen_bits(Z);
    run(Z, 0, 0);
    check("k_z", k_obs, Z);
    check("crc_z", n_crc, 0);

    for (int r = 0; r < 6; r++) begin
      b = (r == 5) ? $urandom_range(6200, 9000) : $urandom_range(1, 1500);
      gen_bits(b);
      run(b, 2, 0);
    end

`ifdef CB_SEG_SIZE_CHECK_EN
    tb_size = '0;
    size_vld = 1'b1;
    tb_vld = 1'b1;
    cb_rdy = 1'b1;
    @(posedge clk); #1;
    size_vld = 1'b0;
    check("err_pulse", {err, busy, tb_rdy, size_rdy}, 4'b1001);
    @(posedge clk); #1;
    check("err_clear", {err, busy, tb_rdy, size_rdy}, 4'b0001);
    tb_vld = 1'b0;
`else
    tb_bits.delete();
    run(0, 2, 0);
    check("k_0", k_obs, KGRAN);
    check("fill_0", n_fill, KGRAN);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
